// File: rtl/axi_adc_lite_pkg.sv
// Shared constants and types for the AXI_ADC AXI4-Lite control register bank.
package axi_adc_lite_pkg;

    // AXI response codes used by this slave
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte address -> word index shift
    localparam int ADDR_LSB = 2;

    // Register map for the default four-register configuration
    localparam int DEFAULT_NUM_REGS = 4;
    localparam int REG_CTRL         = 0;
    localparam int REG_CFG          = 1;
    localparam int REG_THRESH       = 2;
    localparam int REG_AUX          = 3;
    localparam int REG_STATUS       = DEFAULT_NUM_REGS;

    // Write response channel states
    typedef enum logic {
        B_IDLE = 1'b0,
        B_RESP = 1'b1
    } b_state_e;

    // Read data channel states
    typedef enum logic {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } r_state_e;

    // Merge new write data into an old word, one byte lane per strobe bit
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_adc_lite_regs.sv
// AXI4-Lite slave register bank for the ADC control interface: NUM_REGS
// read/write words, one read-only live ADC status word, per-register write pulses.
//
// Handshake rule on every channel: a beat transfers on a rising clock edge where
// VALID and READY are both high. A source holds VALID and its payload stable
// until that edge; this slave never makes VALID depend on READY, and its READY
// outputs depend only on registered state.
module axi_adc_lite_regs
    import axi_adc_lite_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [31:0]                     adc_status,
    output logic [NUM_REGS*32-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;

    // READY outputs stay low until the first clock after reset release
    logic ready_en_q;

    // Write address / data holding slots
    logic             aw_held_q, aw_held_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             w_held_q, w_held_d;
    logic [DW-1:0]    w_data_q, w_data_d;
    logic [SW-1:0]    w_strb_q, w_strb_d;

    // Response channel state
    b_state_e         b_state_q, b_state_d;
    logic [1:0]       bresp_q, bresp_d;
    r_state_e         r_state_q, r_state_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    // Register array and commit pulses
    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             commit;
    logic             wr_in_range;
    logic [IDX_W-1:0] ar_idx;

    // Protection bits and byte-offset address bits carry no meaning here
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign S_AXI_AWREADY = ready_en_q & ~aw_held_q;
    assign S_AXI_WREADY  = ready_en_q & ~w_held_q;
    assign S_AXI_ARREADY = ready_en_q & (r_state_q == R_IDLE);
    assign S_AXI_BVALID  = (b_state_q == B_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = (r_state_q == R_VALID);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse  = wr_pulse_q;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

    // A write commits once both halves are held and no response is outstanding
    assign commit      = aw_held_q & w_held_q & (b_state_q == B_IDLE);
    assign wr_in_range = (32'(aw_idx_q) < NUM_REGS);

    genvar gi;
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
        assign reg_out[32*gi +: 32] = regs_q[gi];
    end

    // Write channel holding slots: fill on handshake, empty on commit
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = S_AXI_WDATA;
                w_strb_d = S_AXI_WSTRB;
            end
        end
    end

    // Register array update and one-cycle write pulses on commit
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i]     = regs_q[i];
            wr_pulse_d[i] = 1'b0;
            if (commit && wr_in_range && (32'(aw_idx_q) == i)) begin
                regs_d[i]     = apply_wstrb(regs_q[i], w_data_q, w_strb_q);
                wr_pulse_d[i] = 1'b1;
            end
        end
    end

    // Write response FSM: raise BVALID after commit, hold until BREADY
    always_comb begin
        b_state_d = b_state_q;
        bresp_d   = bresp_q;
        case (b_state_q)
            B_IDLE: begin
                if (commit) begin
                    b_state_d = B_RESP;
                    bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            B_RESP: begin
                if (S_AXI_BREADY) begin
                    b_state_d = B_IDLE;
                end
            end
            default: b_state_d = B_IDLE;
        endcase
    end

    // Read FSM: decode on AR handshake using pre-write register contents
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_VALID;
                    rdata_d   = '0;
                    rresp_d   = RESP_SLVERR;
                    if (32'(ar_idx) == NUM_REGS) begin
                        rdata_d = adc_status;
                        rresp_d = RESP_OKAY;
                    end
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (32'(ar_idx) == i) begin
                            rdata_d = regs_q[i];
                            rresp_d = RESP_OKAY;
                        end
                    end
                end
            end
            R_VALID: begin
                if (S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State registers; reset drops any buffered address/data and pending response
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_state_q  <= B_IDLE;
            bresp_q    <= RESP_OKAY;
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_state_q  <= b_state_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_adc_lite_regs.sv
// Self-checking bench for axi_adc_lite_regs: directed scenarios plus random
// traffic checked against a word-level model of the register map.
module tb_axi_adc_lite_regs;

    localparam int AW = 5;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     awaddr = '0;
    logic [2:0]        awprot = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [AW-1:0]     araddr = '0;
    logic [2:0]        arprot = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [31:0]       adc = '0;
    logic [NR*32-1:0]  reg_out;
    logic [NR-1:0]     reg_wr_pulse;

    int total = 0;
    int bad   = 0;

    // Reference model: the four RW words as seen by software
    logic [31:0] model [NR];
    logic [31:0] exp_q [$];

    axi_adc_lite_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .adc_status(adc), .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic int word_of(input logic [AW-1:0] addr);
        return int'(addr) / 4;
    endfunction

    function automatic logic [31:0] exp_read(input logic [AW-1:0] addr);
        int idx;
        idx = word_of(addr);
        if (idx < NR) return model[idx];
        if (idx == NR) return adc;
        return 32'h0;
    endfunction

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    // Drive AW and W; W leads AW by w_lead cycles. Returns #1 after the last handshake edge.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (cyc >= w_lead && !aw_done) awvalid = 1'b1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            total++; bad++;
            $display("FAIL write_handshake: addr=%0h aw_done=%0d w_done=%0d, required both accepted", addr, aw_done, w_done);
        end
    endtask

    // Wait for BVALID with BREADY high; check response, pulse, and pulse width.
    task automatic wait_b(input string name, input logic [1:0] exp_resp, input logic [NR-1:0] exp_pulse);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (!bvalid) begin
            bad++;
            $display("FAIL %s_bvalid: BVALID never rose, required a response", name);
            return;
        end
        total++;
        if (bresp !== exp_resp) begin
            bad++; $display("FAIL %s_bresp: got %b, required %b", name, bresp, exp_resp);
        end
        total++;
        if (reg_wr_pulse !== exp_pulse) begin
            bad++; $display("FAIL %s_pulse: got %b, required %b", name, reg_wr_pulse, exp_pulse);
        end
        @(posedge clk); #1;
        total++;
        if (reg_wr_pulse !== '0 || bvalid !== 1'b0) begin
            bad++; $display("FAIL %s_after_b: pulse=%b bvalid=%b, required 0 and 0", name, reg_wr_pulse, bvalid);
        end
    endtask

    // Full write: handshake, model update, response check, register image check.
    task automatic do_write(input string name, input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead);
        int idx;
        logic [1:0] er;
        logic [NR-1:0] ep;
        idx = word_of(addr);
        er  = 2'b10;
        ep  = '0;
        if (idx < NR) begin
            er = 2'b00;
            ep[idx] = 1'b1;
            model[idx] = byte_merge(model[idx], data, strb);
        end
        axi_write(addr, data, strb, w_lead);
        wait_b(name, er, ep);
        total++;
        if (reg_out !== model_flat()) begin
            bad++; $display("FAIL %s_reg_out: got %h, required %h", name, reg_out, model_flat());
        end
    endtask

    // Single read with latency-1 check against the model.
    task automatic axi_read(input string name, input logic [AW-1:0] addr);
        int n = 0;
        logic [31:0] ed;
        logic [1:0]  er;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        ed = exp_read(addr);
        er = (word_of(addr) <= NR) ? 2'b00 : 2'b10;
        @(posedge clk); #1;
        arvalid = 1'b0;
        total++;
        if (rvalid !== 1'b1) begin
            bad++; $display("FAIL %s_rvalid: got %b one cycle after AR, required 1", name, rvalid);
        end else begin
            total++;
            if (rdata !== ed || rresp !== er) begin
                bad++; $display("FAIL %s_rdata: got %h/%b, required %h/%b", name, rdata, rresp, ed, er);
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < NR; i++) model[i] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 || rresp !== 2'b00
            || rdata !== 32'h0 || reg_out !== '0 || reg_wr_pulse !== '0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h reg_out=%h pulse=%b, required all 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_out, reg_wr_pulse);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++; $display("FAIL reset_release_ready: got %b, required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic_rw();
        for (int i = 0; i < NR; i++) do_write("basic_wr", AW'(4 * i), 32'(i + 1), 4'hF, 0);
        for (int i = 0; i < NR; i++) axi_read("basic_rd", AW'(4 * i));
    endtask

    task automatic test_w_first();
        do_write("w_first", 5'h04, 32'hDEADBEEF, 4'hF, 3);
        axi_read("w_first_rd", 5'h04);
    endtask

    task automatic test_strobe();
        do_write("strb_full", 5'h00, 32'hFFFFFFFF, 4'hF, 0);
        do_write("strb_part", 5'h00, 32'h00000000, 4'b0101, 1);
        total++;
        if (reg_out[31:0] !== 32'hFF00FF00) begin
            bad++; $display("FAIL strb_value: got %h, required ff00ff00", reg_out[31:0]);
        end
        do_write("strb_none", 5'h00, 32'h12345678, 4'b0000, 0);
        axi_read("strb_rd", 5'h00);
    endtask

    task automatic test_status();
        do_write("status_wr", 5'h10, 32'h12345678, 4'hF, 0);
        do_write("oor_wr", 5'h1C, 32'hCAFEF00D, 4'hF, 2);
        adc = 32'h00000ABC;
        axi_read("status_rd", 5'h10);
        axi_read("status_unaligned_rd", 5'h13);
        axi_read("oor_rd", 5'h14);
    endtask

    task automatic test_backpressure();
        int n = 0;
        bit stable_ok = 1;
        logic [NR*32-1:0] snap;
        bready = 1'b0;
        model[2] = 32'hA5A5A5A5;
        axi_write(5'h08, 32'hA5A5A5A5, 4'hF, 0);
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        axi_write(5'h0C, 32'h5A5A5A5A, 4'hF, 0);
        total++;
        if (awready !== 1'b0 || wready !== 1'b0) begin
            bad++; $display("FAIL bp_hold_full: awready=%b wready=%b, required 0 0", awready, wready);
        end
        snap = model_flat();
        repeat (8) begin
            @(posedge clk); #1;
            if (bvalid !== 1'b1 || reg_out !== snap || awready !== 1'b0) stable_ok = 0;
        end
        total++;
        if (!stable_ok) begin
            bad++; $display("FAIL bp_stall: bvalid=%b reg_out=%h, required 1 and %h with no second commit", bvalid, reg_out, snap);
        end
        model[3] = 32'h5A5A5A5A;
        bready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bvalid !== 1'b0) begin
            bad++; $display("FAIL bp_first_b_taken: bvalid=%b, required 0", bvalid);
        end
        wait_b("bp_second", 2'b00, 4'b1000);
        total++;
        if (reg_out !== model_flat()) begin
            bad++; $display("FAIL bp_reg_out: got %h, required %h", reg_out, model_flat());
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [31:0] old_v;
        old_v = model[2];
        axi_write(5'h08, 32'h0BADC0DE, 4'hF, 0);
        araddr  = 5'h08;
        arvalid = 1'b1;
        rready  = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        total++;
        if (rvalid !== 1'b1 || rdata !== old_v) begin
            bad++; $display("FAIL same_cycle_rd: rvalid=%b rdata=%h, required 1 and %h", rvalid, rdata, old_v);
        end
        model[2] = 32'h0BADC0DE;
        wait_b("same_cycle_wr", 2'b00, 4'b0100);
        axi_read("same_cycle_after", 5'h08);
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int cyc = 0;
        int got = 0;
        bit hs;
        logic [31:0] d;
        bready  = 1'b1;
        d       = $urandom;
        awaddr  = 5'h00;
        wdata   = d;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (k < NR && cyc < 50) begin
            hs = awvalid && awready && wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                model[k] = d;
                k++;
                if (k < NR) begin
                    d = $urandom;
                    awaddr = AW'(4 * k);
                    wdata = d;
                end else begin
                    awvalid = 1'b0;
                    wvalid  = 1'b0;
                end
            end
        end
        total++;
        if (cyc != 7) begin
            bad++; $display("FAIL b2b_write_rate: %0d writes took %0d cycles, required 7", k, cyc);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (reg_out !== model_flat() || bvalid !== 1'b0) begin
            bad++; $display("FAIL b2b_write_data: reg_out=%h bvalid=%b, required %h and 0", reg_out, bvalid, model_flat());
        end
        // Reads with ARVALID held continuously
        k = 0;
        cyc = 0;
        rready  = 1'b1;
        araddr  = 5'h00;
        arvalid = 1'b1;
        while (got < NR && cyc < 50) begin
            hs = arvalid && arready;
            if (hs) exp_q.push_back(exp_read(araddr));
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                k++;
                if (k < NR) araddr = AW'(4 * k);
                else arvalid = 1'b0;
            end
            if (rvalid) begin
                total++;
                if (exp_q.size() == 0 || rdata !== exp_q[0]) begin
                    bad++; $display("FAIL b2b_read_data: got %h, required %h", rdata,
                                    (exp_q.size() == 0) ? 32'h0 : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
        end
        arvalid = 1'b0;
        total++;
        if (cyc != 7) begin
            bad++; $display("FAIL b2b_read_rate: %0d reads took %0d cycles, required 7", got, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int it = 0; it < 40; it++) begin
            a = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                do_write("rand_wr", a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            end else begin
                adc = $urandom;
                axi_read("rand_rd", a);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit quiet = 1;
        bready = 1'b0;
        axi_write(5'h00, 32'h00000055, 4'hF, 0);
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        awaddr  = 5'h04;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || reg_out !== '0 || awready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_state: bvalid=%b rvalid=%b awready=%b reg_out=%h, required all 0",
                            bvalid, rvalid, awready, reg_out);
        end
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        bready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Data alone must not commit: the held address was discarded by reset
        wdata  = 32'h00000077;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        n = 0;
        while (!wready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bvalid !== 1'b0 || reg_out !== '0) quiet = 0;
        end
        total++;
        if (!quiet) begin
            bad++; $display("FAIL rst_mid_stray: bvalid=%b reg_out=%h, required no response and zero regs", bvalid, reg_out);
        end
        model[1] = 32'h00000077;
        awaddr  = 5'h04;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        wait_b("rst_mid_recover", 2'b00, 4'b0010);
        total++;
        if (reg_out !== model_flat()) begin
            bad++; $display("FAIL rst_mid_reg_out: got %h, required %h", reg_out, model_flat());
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_basic_rw();
        test_w_first();
        test_strobe();
        test_status();
        test_backpressure();
        test_same_cycle_rw();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
